branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4: in-flight prediction entries (power of two, >=2).
REQ-002 SHALL have parameter PTR_W, default 2: log2(QUEUE_DEPTH).
REQ-003 SHALL have port clk, input, 1: clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port fetch_valid, input, 1: IF issues an instruction with its prediction.
REQ-006 SHALL have port fetch_pc, input, 32: PC of the fetched instruction.
REQ-007 SHALL have port fetch_taken_pred, input, 1: predictor taken bit.
REQ-008 SHALL have port fetch_target_pred, input, 32: predictor target PC.
REQ-009 SHALL have port fetch_ready, output, 1: entry can be accepted this cycle.
REQ-010 SHALL have port ex_valid, input, 1: instruction resolves in EX this cycle.
REQ-011 SHALL have port ex_pc, input, 32: PC of the resolving instruction.
REQ-012 SHALL have port ex_is_br, input, 1: resolving instruction is an immediate-target conditional branch.
REQ-013 SHALL have port ex_taken, input, 1: actual branch outcome.
REQ-014 SHALL have port ex_target, input, 32: actual branch target.
REQ-015 SHALL have ports commit_valid, commit_imm, commit_taken (output, 1 each) and commit_pc, commit_target (output, 32 each): predictor update interface.
REQ-016 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32): fetch redirect on mispredict.
REQ-017 SHALL have port queue_count, output, PTR_W+1: occupied entries.
REQ-018 SHALL have ports branch_cnt and mispred_cnt, output, 32 each: performance counters.

Function
REQ-019 SHALL hold entries {pc, taken_pred, target_pred} in a FIFO; enqueue when fetch_valid & fetch_ready.
REQ-020 SHALL drive fetch_ready = (state==RUN) & (queue_count != QUEUE_DEPTH).
REQ-021 SHALL pop the head when ex_valid is accepted in RUN; simultaneous push and pop SHALL leave queue_count unchanged; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-022 SHALL compute actual_next = (ex_is_br & ex_taken) ? ex_target : ex_pc+4, and pred_next = head.taken_pred ? head.target_pred : head.pc+4 (32-bit wrap).
REQ-023 SHALL flag a mispredict when actual_next != pred_next, or head.pc != ex_pc, or the queue is empty at ex_valid.
REQ-024 SHALL register commit_valid=ex_valid, commit_imm=ex_is_br, commit_taken=ex_taken, commit_pc=ex_pc, commit_target=ex_target; these are visible exactly one cycle after the EX cycle, for one cycle only.
REQ-025 SHALL use a two-state FSM: RUN -> REDIRECT on mispredict; REDIRECT -> RUN unconditionally after one cycle.
REQ-026 In REDIRECT SHALL assert redirect_valid=1 with redirect_pc=actual_next, fetch_ready=0, ignore ex_valid (wrong path), and emit no commit.
REQ-027 On mispredict SHALL flush the FIFO (queue_count=0, pointers equal) at the next edge, discarding any same-cycle enqueue.
REQ-028 SHALL keep redirect_valid=0 in RUN.

Reset
REQ-029 On rst SHALL force state RUN, pointers 0, queue_count 0, every commit_* 0, redirect_valid 0, redirect_pc 0, branch_cnt 0, mispred_cnt 0.
REQ-030 rst mid-REDIRECT SHALL return to RUN next cycle with no redirect pulse.

Configuration
REQ-031 With BR_PERF_CNT_EN defined, branch_cnt SHALL increment on each accepted ex_valid & ex_is_br and mispred_cnt on each mispredict, both wrapping at 2^32.
REQ-032 Without BR_PERF_CNT_EN, branch_cnt and mispred_cnt SHALL be tied to 0 and no counter registers synthesised.

Verification
REQ-033 Fill: 4 fetches, no ex_valid -> queue_count=4, fetch_ready=0; 5th fetch not accepted.
REQ-034 Correct predict: fetch pc 0x100 taken_pred=1 target 0x200; ex pc 0x100 br taken target 0x200 -> next cycle commit_valid=1, commit_taken=1, redirect_valid=0, queue_count=0.
REQ-035 Mispredict: fetch pc 0x100 taken_pred=0; ex pc 0x100 br taken target 0x80 -> next cycle redirect_valid=1, redirect_pc=0x80, queue_count=0, mispred_cnt=1 (with macro).
REQ-036 Simultaneous push/pop at count 2 -> count stays 2; pointer wrap verified over 9 push/pop pairs.
REQ-037 Empty queue ex_valid pc 0x40 non-branch -> redirect_pc=0x44; ex_valid in REDIRECT cycle -> no commit_valid.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch prediction tracking queue, mispredict detection and fetch redirect
// Optional feature macro: BR_PERF_CNT_EN (branch / mispredict performance counters)
module branch_resolve_unit #(
   parameter int QUEUE_DEPTH = 4,
   parameter int PTR_W       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid,
   input  logic [31:0]       fetch_pc,
   input  logic              fetch_taken_pred,
   input  logic [31:0]       fetch_target_pred,
   output logic              fetch_ready,
   input  logic              ex_valid,
   input  logic [31:0]       ex_pc,
   input  logic              ex_is_br,
   input  logic              ex_taken,
   input  logic [31:0]       ex_target,
   output logic              commit_valid,
   output logic              commit_imm,
   output logic              commit_taken,
   output logic [31:0]       commit_pc,
   output logic [31:0]       commit_target,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic [PTR_W:0]    queue_count,
   output logic [31:0]       branch_cnt,
   output logic [31:0]       mispred_cnt
);

   typedef enum logic {S_RUN = 1'b0, S_REDIRECT = 1'b1} state_t;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(QUEUE_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   state_t            state, state_next;
   logic [31:0]       q_pc     [QUEUE_DEPTH];
   logic              q_taken  [QUEUE_DEPTH];
   logic [31:0]       q_target [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;

   logic              ex_accept, q_empty, push, pop, mispredict;
   logic [31:0]       actual_next, pred_next;

   assign queue_count = count;
   assign q_empty     = (count == '0);
   // Wrong-path resolutions arriving while redirecting are dropped entirely.
   assign ex_accept   = ex_valid && (state == S_RUN);
   assign push        = fetch_valid && fetch_ready;
   assign pop         = ex_accept && !q_empty;

   // Compare the resolved next PC against what the head entry predicted
   always_comb begin
      actual_next = (ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;
      pred_next   = q_taken[rd_ptr] ? q_target[rd_ptr] : q_pc[rd_ptr] + 32'd4;
      mispredict  = ex_accept &&
                    (q_empty || (q_pc[rd_ptr] != ex_pc) || (actual_next != pred_next));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_next;
   end

   // Next-state: one redirect cycle per mispredict, then back to RUN
   always_comb begin
      state_next = state;
      case (state)
         S_RUN:      if (mispredict) state_next = S_REDIRECT;
         S_REDIRECT: state_next = S_RUN;
         default:    state_next = S_RUN;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      fetch_ready    = (state == S_RUN) && (count != CNT_FULL);
      redirect_valid = (state == S_REDIRECT);
   end

   // Prediction storage; entries need no reset since count guards them
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]     <= fetch_pc;
         q_taken[wr_ptr]  <= fetch_taken_pred;
         q_target[wr_ptr] <= fetch_target_pred;
      end
   end

   // Pointers and occupancy; a mispredict flushes and overrides any push/pop
   always_ff @(posedge clk) begin
      if (rst || mispredict) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Predictor update pulse, one cycle after the resolving EX cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid  <= 1'b0;
         commit_imm    <= 1'b0;
         commit_taken  <= 1'b0;
         commit_pc     <= '0;
         commit_target <= '0;
      end else begin
         commit_valid  <= ex_accept;
         commit_imm    <= ex_is_br;
         commit_taken  <= ex_taken;
         commit_pc     <= ex_pc;
         commit_target <= ex_target;
      end
   end

   // Capture the correct-path PC for the redirect cycle
   always_ff @(posedge clk) begin
      if (rst)             redirect_pc <= '0;
      else if (mispredict) redirect_pc <= actual_next;
   end

`ifdef BR_PERF_CNT_EN
   logic [31:0] br_cnt_q, mis_cnt_q;

   // Performance counters, free-running with natural 32-bit wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (ex_accept && ex_is_br) br_cnt_q  <= br_cnt_q + 32'd1;
         if (mispredict)            mis_cnt_q <= mis_cnt_q + 32'd1;
      end
   end

   assign branch_cnt  = br_cnt_q;
   assign mispred_cnt = mis_cnt_q;
`else
   assign branch_cnt  = 32'd0;
   assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid, fetch_taken_pred, fetch_ready;
   logic [31:0] fetch_pc, fetch_target_pred;
   logic        ex_valid, ex_is_br, ex_taken;
   logic [31:0] ex_pc, ex_target;
   logic        commit_valid, commit_imm, commit_taken;
   logic [31:0] commit_pc, commit_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  queue_count;
   logic [31:0] branch_cnt, mispred_cnt;

   branch_resolve_unit #(.QUEUE_DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .fetch_taken_pred(fetch_taken_pred), .fetch_target_pred(fetch_target_pred),
      .fetch_ready(fetch_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_br(ex_is_br),
      .ex_taken(ex_taken), .ex_target(ex_target),
      .commit_valid(commit_valid), .commit_imm(commit_imm), .commit_taken(commit_taken),
      .commit_pc(commit_pc), .commit_target(commit_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .queue_count(queue_count), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        tp;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      logic        cv;
      logic        imm;
      logic        tk;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   logic        m_run;
   int unsigned m_br, m_mis;
   int          checks = 0;
   int          errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_counters();
`ifdef BR_PERF_CNT_EN
      check_eq("branch_cnt", branch_cnt, m_br);
      check_eq("mispred_cnt", mispred_cnt, m_mis);
`else
      check_eq("branch_cnt", branch_cnt, 32'd0);
      check_eq("mispred_cnt", mispred_cnt, 32'd0);
`endif
   endtask

   // One clock: drive at posedge+1, model the edge, compare at next posedge+1
   task automatic cycle(input logic fv, input logic [31:0] fpc, input logic ftp,
                        input logic [31:0] ftgt, input logic ev, input logic [31:0] epc,
                        input logic ebr, input logic etk, input logic [31:0] etgt);
      exp_t        e;
      ent_t        n;
      logic        m_ready, acc, mis;
      logic [31:0] act, prd;
      fetch_valid = fv; fetch_pc = fpc; fetch_taken_pred = ftp; fetch_target_pred = ftgt;
      ex_valid = ev; ex_pc = epc; ex_is_br = ebr; ex_taken = etk; ex_target = etgt;
      #1;
      m_ready = m_run && (mq.size() < DEPTH);
      check_eq("fetch_ready", {31'd0, fetch_ready}, {31'd0, m_ready});
      acc = ev && m_run;
      act = (ebr && etk) ? etgt : epc + 32'd4;
      mis = 1'b0;
      if (acc) begin
         if (mq.size() == 0) mis = 1'b1;
         else begin
            prd = mq[0].tp ? mq[0].tgt : mq[0].pc + 32'd4;
            mis = (mq[0].pc != epc) || (act != prd);
         end
      end
      if (ev) begin
         e = '{cv: acc, imm: ebr, tk: etk, pc: epc, tgt: etgt, rv: mis, rpc: act};
         sb.push_back(e);
      end
      if (acc && ebr) m_br++;
      if (mis) begin
         m_mis++;
         mq.delete();
      end else begin
         if (acc && mq.size() > 0) void'(mq.pop_front());
         if (fv && m_ready) begin
            n = '{pc: fpc, tp: ftp, tgt: ftgt};
            mq.push_back(n);
         end
      end
      m_run = !mis;
      @(posedge clk);
      #1;
      if (ev) begin
         e = sb.pop_front();
         check_eq("commit_valid", {31'd0, commit_valid}, {31'd0, e.cv});
         if (e.cv) begin
            check_eq("commit_pc", commit_pc, e.pc);
            check_eq("commit_imm", {31'd0, commit_imm}, {31'd0, e.imm});
            check_eq("commit_taken", {31'd0, commit_taken}, {31'd0, e.tk});
            check_eq("commit_target", commit_target, e.tgt);
         end
         if (e.rv) check_eq("redirect_pc", redirect_pc, e.rpc);
      end else begin
         check_eq("commit_idle", {31'd0, commit_valid}, 32'd0);
      end
      check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, !m_run});
      check_eq("queue_count", {29'd0, queue_count}, mq.size());
   endtask

   task automatic fetch_only(input logic [31:0] pc);
      cycle(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic idle();
      cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] hpc, rpc, rtgt;
      logic        rbr, rtk, rtp;
      rst = 1'b1; m_run = 1'b1; m_br = 0; m_mis = 0;
      fetch_valid = 0; fetch_pc = 0; fetch_taken_pred = 0; fetch_target_pred = 0;
      ex_valid = 0; ex_pc = 0; ex_is_br = 0; ex_taken = 0; ex_target = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      check_eq("rst_queue_count", {29'd0, queue_count}, 32'd0);
      check_eq("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
      check_eq("rst_commit_pc", commit_pc, 32'd0);
      check_eq("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check_eq("rst_redirect_pc", redirect_pc, 32'd0);
      check_eq("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
      check_counters();

      // fill to depth, fifth fetch must be refused, then drain in order
      for (int i = 0; i < 5; i++) fetch_only(32'h10 + 32'(i) * 4);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 0, 0, 0, 1'b1, 32'h10 + 32'(i) * 4, 1'b0, 1'b0, 32'd0);

      // correct taken prediction
      cycle(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 0, 0, 0, 0);
      cycle(1'b0, 0, 0, 0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);

      // mispredict, then wrong-path ex_valid during redirect
      cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 0, 0, 0, 0);
      cycle(1'b1, 32'h104, 1'b0, 0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h80);
      check_counters();
      cycle(1'b1, 32'h84, 1'b0, 0, 1'b1, 32'h84, 1'b1, 1'b0, 32'h0);

      // steady push/pop at count 2 across pointer wrap
      fetch_only(32'h1000);
      fetch_only(32'h1004);
      for (int i = 0; i < 9; i++)
         cycle(1'b1, 32'h1008 + 32'(i) * 4, 1'b0, 0, 1'b1, mq[0].pc, 1'b0, 1'b0, 0);
      while (mq.size() > 0) cycle(1'b0, 0, 0, 0, 1'b1, mq[0].pc, 1'b0, 1'b0, 0);

      // empty-queue resolution, then reset in the middle of the redirect
      cycle(1'b0, 0, 0, 0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_run = 1'b1; m_br = 0; m_mis = 0; mq.delete();
      check_eq("rstmid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check_eq("rstmid_redirect_pc", redirect_pc, 32'd0);
      check_eq("rstmid_fetch_ready", {31'd0, fetch_ready}, 32'd1);
      check_eq("rstmid_commit_valid", {31'd0, commit_valid}, 32'd0);
      check_counters();

      // random mix of fetch and resolution traffic
      for (int i = 0; i < 80; i++) begin
         rtp  = 1'($urandom_range(0, 1));
         rbr  = 1'($urandom_range(0, 1));
         rtgt = {$urandom_range(0, 255), 2'b00};
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            hpc  = mq[0].pc;
            rtk  = ($urandom_range(0, 5) != 0) ? mq[0].tp : !mq[0].tp;
            rbr  = rtk ? 1'b1 : rbr;
            rtgt = ($urandom_range(0, 5) != 0) ? mq[0].tgt : rtgt;
         end else begin
            hpc = {$urandom_range(0, 255), 2'b00};
            rtk = 1'($urandom_range(0, 1));
         end
         rpc = {$urandom_range(0, 255), 2'b00};
         cycle(1'($urandom_range(0, 1)), rpc, rtp, {$urandom_range(0, 255), 2'b00},
               ($urandom_range(0, 2) == 0), hpc, rbr, rtk, rtgt);
      end
      idle();
      check_counters();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
